// File: rtl/solver_pkg.sv
// Shared constants and state encoding for the iterative solver sequencer.
package solver_pkg;

    localparam int DATA_W         = 32;
    localparam int PU_LATENCY_DEF = 2;
    localparam int MAX_ITER_DEF   = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_WAIT   = ST_WAIT,
        S_CHECK  = ST_CHECK,
        S_UPDATE = ST_UPDATE,
        S_DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/solver_controller_if.sv
// Host handshake plus datapath strobe/status bundle of the solver sequencer.
interface solver_controller_if
    import solver_pkg::*;
#(
    parameter int CNT_W = 5
);
    logic              start;
    logic              zer;
    logic [DATA_W-1:0] dp_out;
    logic              wen;
    logic              wene;
    logic              sel;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  iters;
    logic              timeout;

    // Host/datapath side
    modport master (
        output start, zer, dp_out,
        input  wen, wene, sel, ready, done, result, iters, timeout
    );

    // Controller side
    modport slave (
        input  start, zer, dp_out,
        output wen, wene, sel, ready, done, result, iters, timeout
    );

endinterface

// File: rtl/solver_controller.sv
// Load / wait / check / feedback-update sequencer for the four-lane iterative datapath.
// Terminates on datapath zero-detect or on the iteration cap and reports via start/ready/done.
module solver_controller
    import solver_pkg::*;
#(
    parameter int PU_LATENCY = PU_LATENCY_DEF,
    parameter int MAX_ITER   = MAX_ITER_DEF,
    parameter int CNT_W      = 5
) (
    input  logic                clk,
    input  logic                rst,
    solver_controller_if.slave  bus
);

    localparam int WAIT_W = (PU_LATENCY > 1) ? $clog2(PU_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(PU_LATENCY - 1);
    localparam logic [CNT_W-1:0]  ITER_CAP  = CNT_W'(MAX_ITER - 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic [DATA_W-1:0]  cap_q, cap_d;
    logic               tnxt_q, tnxt_d;

    logic               wen_q, wen_d;
    logic               wene_q, wene_d;
    logic               sel_q, sel_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]   iters_q, iters_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        iter_d  = iter_q;
        cap_d   = cap_q;
        tnxt_d  = tnxt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    iter_d  = '0;
                end
            end
            S_LOAD: begin
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_CHECK: begin
                // The cap is tested before any increment, so iter_cnt cannot wrap.
                cap_d = bus.dp_out;
                if (bus.zer) begin
                    state_d = S_DONE;
                    tnxt_d  = 1'b0;
                end else if (iter_q == ITER_CAP) begin
                    state_d = S_DONE;
                    tnxt_d  = 1'b1;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                iter_d  = iter_q + 1'b1;
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        wen_d     = (state_d == S_LOAD) || (state_d == S_UPDATE);
        wene_d    = (state_d == S_LOAD);
        sel_d     = (state_d == S_UPDATE);
        ready_d   = (state_d == S_IDLE);
        done_d    = (state_q == S_DONE);
        result_d  = result_q;
        iters_d   = iters_q;
        timeout_d = timeout_q;
        if (state_q == S_DONE) begin
            result_d  = cap_q;
            iters_d   = iter_q;
            timeout_d = tnxt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            iter_q    <= '0;
            tnxt_q    <= 1'b0;
            wen_q     <= 1'b0;
            wene_q    <= 1'b0;
            sel_q     <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            result_q  <= '0;
            iters_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            iter_q    <= iter_d;
            tnxt_q    <= tnxt_d;
            wen_q     <= wen_d;
            wene_q    <= wene_d;
            sel_q     <= sel_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            result_q  <= result_d;
            iters_q   <= iters_d;
            timeout_q <= timeout_d;
        end
    end

    // Captured word is only consumed after CHECK has written it, so it needs no reset.
    always_ff @(posedge clk) begin
        cap_q <= cap_d;
    end

    assign bus.wen     = wen_q;
    assign bus.wene    = wene_q;
    assign bus.sel     = sel_q;
    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.iters   = iters_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_solver_controller.sv
// Directed bench for solver_controller with PU_LATENCY=2, MAX_ITER=4.
module tb_solver_controller;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    int          load_k[$];
    int          fb_k[$];
    int          done_k[$];
    logic [31:0] last_res;
    logic [4:0]  last_iters;
    logic        last_to;

    solver_controller_if #(.CNT_W(5)) bus ();

    solver_controller #(
        .PU_LATENCY (2),
        .MAX_ITER   (4),
        .CNT_W      (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    // Drives one run. Index k = observation just after the k-th edge following the start edge.
    // smask[k] is the start level driven after observation k; zer rises once zer_after
    // feedback writes have been seen since the last load (-1 = never).
    task automatic run(input logic [31:0] smask, input int zer_after, input logic [31:0] dv,
                       input int max_k, input bit stop_on_done);
        int fb_since;
        load_k.delete();
        fb_k.delete();
        done_k.delete();
        fb_since = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dp_out = dv;
        bus.zer    = (zer_after == 0);
        @(posedge clk);
        for (int k = 0; k < max_k; k++) begin
            @(negedge clk);
            bus.start = smask[k];
            if (bus.wen && bus.wene && !bus.sel) begin
                load_k.push_back(k);
                fb_since = 0;
            end
            if (bus.wen && bus.sel && !bus.wene) begin
                fb_k.push_back(k);
                fb_since++;
            end
            if (bus.done) begin
                done_k.push_back(k);
                last_res   = bus.result;
                last_iters = bus.iters;
                last_to    = bus.timeout;
            end
            bus.zer = (zer_after >= 0) && (fb_since >= zer_after);
            if (stop_on_done && bus.done) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.wen !== 1'b0) $display("FAIL reset_wen got %b want 0", bus.wen); else n_pass++;
        n_checks++; if (bus.wene !== 1'b0) $display("FAIL reset_wene got %b want 0", bus.wene); else n_pass++;
        n_checks++; if (bus.sel !== 1'b0) $display("FAIL reset_sel got %b want 0", bus.sel); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.result !== 32'h0) $display("FAIL reset_result got %h want 0", bus.result); else n_pass++;
        n_checks++; if (bus.iters !== 5'd0) $display("FAIL reset_iters got %0d want 0", bus.iters); else n_pass++;
        n_checks++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", bus.timeout); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_immediate();
        int d0;
        run(32'h0, 0, 32'h0000_00A5, 20, 1'b1);
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        n_checks++; if (load_k.size() !== 1 || load_k[0] !== 0)
            $display("FAIL imm_load count %0d want 1 at k=0", load_k.size()); else n_pass++;
        n_checks++; if (fb_k.size() !== 0) $display("FAIL imm_fb got %0d want 0", fb_k.size()); else n_pass++;
        n_checks++; if (d0 !== 5) $display("FAIL imm_done_latency got %0d want 5", d0); else n_pass++;
        n_checks++; if (last_res !== 32'h0000_00A5) $display("FAIL imm_result got %h want 000000a5", last_res); else n_pass++;
        n_checks++; if (last_iters !== 5'd0) $display("FAIL imm_iters got %0d want 0", last_iters); else n_pass++;
        n_checks++; if (last_to !== 1'b0) $display("FAIL imm_timeout got %b want 0", last_to); else n_pass++;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL imm_ready_after got %b want 1", bus.ready); else n_pass++;
    endtask

    task automatic test_cap();
        int d0;
        run(32'h0, -1, 32'h1234_5678, 40, 1'b1);
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        n_checks++; if (fb_k.size() !== 3) $display("FAIL cap_fb_count got %0d want 3", fb_k.size()); else n_pass++;
        n_checks++; if (fb_k.size() != 3 || fb_k[0] !== 4 || fb_k[1] !== 8 || fb_k[2] !== 12)
            $display("FAIL cap_fb_spacing got size %0d want k=4,8,12", fb_k.size()); else n_pass++;
        n_checks++; if (d0 !== 17) $display("FAIL cap_done_latency got %0d want 17", d0); else n_pass++;
        n_checks++; if (last_res !== 32'h1234_5678) $display("FAIL cap_result got %h want 12345678", last_res); else n_pass++;
        n_checks++; if (last_iters !== 5'd3) $display("FAIL cap_iters got %0d want 3", last_iters); else n_pass++;
        n_checks++; if (last_to !== 1'b1) $display("FAIL cap_timeout got %b want 1", last_to); else n_pass++;
    endtask

    task automatic test_converge();
        int d0;
        run(32'h0, 2, 32'hCAFE_0001, 40, 1'b1);
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        n_checks++; if (fb_k.size() !== 2) $display("FAIL conv_fb_count got %0d want 2", fb_k.size()); else n_pass++;
        n_checks++; if (d0 !== 13) $display("FAIL conv_done_latency got %0d want 13", d0); else n_pass++;
        n_checks++; if (last_res !== 32'hCAFE_0001) $display("FAIL conv_result got %h want cafe0001", last_res); else n_pass++;
        n_checks++; if (last_iters !== 5'd2) $display("FAIL conv_iters got %0d want 2", last_iters); else n_pass++;
        n_checks++; if (last_to !== 1'b0) $display("FAIL conv_timeout got %b want 0", last_to); else n_pass++;
    endtask

    task automatic test_zer_wins();
        int d0;
        run(32'h0, 3, 32'h0F0F_0F0F, 40, 1'b1);
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        n_checks++; if (d0 !== 17) $display("FAIL zwin_done_latency got %0d want 17", d0); else n_pass++;
        n_checks++; if (last_iters !== 5'd3) $display("FAIL zwin_iters got %0d want 3", last_iters); else n_pass++;
        n_checks++; if (last_to !== 1'b0) $display("FAIL zwin_timeout got %b want 0", last_to); else n_pass++;
    endtask

    task automatic test_handshake();
        int l1, d0, d1;
        // start pulsed in WAIT (k=1), then held over CHECK, DONE and the IDLE cycle (k=3..5)
        run(32'h0000_003A, 0, 32'h0000_0077, 14, 1'b0);
        l1 = (load_k.size() > 1) ? load_k[1] : -1;
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        d1 = (done_k.size() > 1) ? done_k[1] : -1;
        n_checks++; if (load_k.size() !== 2) $display("FAIL hs_load_count got %0d want 2", load_k.size()); else n_pass++;
        n_checks++; if (l1 !== 6) $display("FAIL hs_second_load got %0d want 6", l1); else n_pass++;
        n_checks++; if (d0 !== 5) $display("FAIL hs_first_done got %0d want 5", d0); else n_pass++;
        n_checks++; if (d1 !== 11) $display("FAIL hs_second_done got %0d want 11", d1); else n_pass++;
    endtask

    task automatic test_abort();
        int fbs, dones, d0;
        fbs = 0;
        dones = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.zer    = 1'b0;
        bus.dp_out = 32'hDEAD_BEEF;
        @(posedge clk);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.wen && bus.sel) fbs++;
            if (k == 9) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (fbs !== 2) $display("FAIL abort_pre_updates got %0d want 2", fbs); else n_pass++;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL abort_ready got %b want 1", bus.ready); else n_pass++;
        n_checks++; if ({bus.wen, bus.wene, bus.sel} !== 3'b000)
            $display("FAIL abort_strobes got %b want 000", {bus.wen, bus.wene, bus.sel}); else n_pass++;
        n_checks++; if (bus.result !== 32'h0) $display("FAIL abort_result got %h want 0", bus.result); else n_pass++;
        n_checks++; if (bus.iters !== 5'd0) $display("FAIL abort_iters got %0d want 0", bus.iters); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones); else n_pass++;
        run(32'h0, 0, 32'h0000_005A, 20, 1'b1);
        d0 = (done_k.size() > 0) ? done_k[0] : -1;
        n_checks++; if (d0 !== 5) $display("FAIL abort_rerun_latency got %0d want 5", d0); else n_pass++;
        n_checks++; if (last_res !== 32'h0000_005A) $display("FAIL abort_rerun_result got %h want 0000005a", last_res); else n_pass++;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.zer    = 1'b0;
        bus.dp_out = 32'h0;
        last_res   = 32'h0;
        last_iters = 5'd0;
        last_to    = 1'b0;
        test_reset();
        test_immediate();
        test_cap();
        test_converge();
        test_zer_wins();
        test_handshake();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
